// File: rtl/err_comp_dec.sv
// Error-compensation decoder: adds expanded quantized error codes onto a base MAC sum, one frame at a time.
// Build option ERR_COMP_SAT_EN: the accumulator saturates on overflow instead of wrapping.
module err_comp_dec #(
    parameter int CODE_W = 14,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ACC_W-1:0]  base_sum,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;
    logic [ACC_W-1:0]  out_sum_q;
    logic [CNT_W-1:0]  out_count_q;
    logic              out_ovf_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [ACC_W-1:0]  code_exp;
    logic [ACC_W:0]    sum_ext;
    logic [ACC_W-1:0]  acc_d;
    logic [CNT_W-1:0]  count_d;
    logic              ovf_d;
    logic              beat;

    // The code holds the MSBs of a 16-bit error; restore its weight by padding LSB zeros.
    generate
        if (CODE_W < 16) begin : g_pad
            assign code_exp = ACC_W'({in_code, {(16 - CODE_W){1'b0}}});
        end else begin : g_nopad
            assign code_exp = ACC_W'(in_code);
        end
    endgenerate

    assign beat = in_valid && in_ready_q;

    always_comb begin
        sum_ext = {1'b0, acc_q} + {1'b0, code_exp};
        ovf_d   = ovf_q | sum_ext[ACC_W];
        count_d = count_q + CNT_W'(1);
`ifdef ERR_COMP_SAT_EN
        // Once overflowed, the frame is pinned at full scale even if later adds carry nothing.
        acc_d   = ovf_d ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
        acc_d   = sum_ext[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q      <= base_sum;
                        count_q    <= '0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_q   <= acc_d;
                        count_q <= count_d;
                        ovf_q   <= ovf_d;
                        if (in_last) begin
                            out_sum_q   <= acc_d;
                            out_count_q <= count_d;
                            out_ovf_q   <= ovf_d;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_err_comp_dec.sv
// Directed bench for err_comp_dec: table of frames plus hand-written multi-cycle sequences.
module tb_err_comp_dec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_sum = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_code = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_sum;
    logic [8:0]  out_count;
    logic        out_ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    err_comp_dec dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_sum  (base_sum),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      base;
        int               n;
        logic [3:0][13:0] codes;
        logic [31:0]      exp_sum;
        logic [8:0]       exp_cnt;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_frame(input logic [31:0] b);
        start = 1'b1;
        base_sum = b;
        tick();
        start = 1'b0;
        chk("start_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic send_beat(input logic [13:0] code, input logic last);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_code = code;
        in_last = last;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("beat_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic close_frame(input string name, input logic [31:0] s,
                               input logic [8:0] c, input logic o);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_sum"}, 64'(out_sum), 64'(s));
        chk({name, "_cnt"}, 64'(out_count), 64'(c));
        chk({name, "_ovf"}, 64'(out_ovf), 64'(o));
        chk({name, "_rdy0"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_vld0"}, 64'(out_valid), 64'd0);
        chk({name, "_held"}, 64'(out_sum), 64'(s));
        $display("frame %s: sum=0x%08h count=%0d ovf=%0d", name, out_sum, out_count, out_ovf);
    endtask

    task automatic set_vec(input int i, input logic [31:0] b, input int n,
                           input logic [13:0] c0, input logic [13:0] c1,
                           input logic [13:0] c2, input logic [13:0] c3,
                           input logic [31:0] s, input logic [8:0] c, input logic o);
        vecs[i].base = b;
        vecs[i].n = n;
        vecs[i].codes[0] = c0;
        vecs[i].codes[1] = c1;
        vecs[i].codes[2] = c2;
        vecs[i].codes[3] = c3;
        vecs[i].exp_sum = s;
        vecs[i].exp_cnt = c;
        vecs[i].exp_ovf = o;
    endtask

    initial begin
        set_vec(0, 32'd100, 3, 14'd1, 14'd2, 14'd3, 14'd0, 32'd124, 9'd3, 1'b0);
        set_vec(1, 32'd0, 1, 14'd16383, 14'd0, 14'd0, 14'd0, 32'd65532, 9'd1, 1'b0);
`ifdef ERR_COMP_SAT_EN
        set_vec(2, 32'hFFFF_FFF0, 1, 14'd8, 14'd0, 14'd0, 14'd0, 32'hFFFF_FFFF, 9'd1, 1'b1);
        set_vec(4, 32'hFFFF_FFFF, 2, 14'd1, 14'd0, 14'd0, 14'd0, 32'hFFFF_FFFF, 9'd2, 1'b1);
`else
        set_vec(2, 32'hFFFF_FFF0, 1, 14'd8, 14'd0, 14'd0, 14'd0, 32'h0000_0010, 9'd1, 1'b1);
        set_vec(4, 32'hFFFF_FFFF, 2, 14'd1, 14'd0, 14'd0, 14'd0, 32'h0000_0003, 9'd2, 1'b1);
`endif
        set_vec(3, 32'd55, 2, 14'd0, 14'd0, 14'd0, 14'd0, 32'd55, 9'd2, 1'b0);
        set_vec(5, 32'd1000, 4, 14'd16383, 14'd16383, 14'd16383, 14'd16383, 32'd263128, 9'd4, 1'b0);

        // Reset state
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_sum", 64'(out_sum), 64'd0);
        chk("rst_cnt", 64'(out_count), 64'd0);
        chk("rst_ovf", 64'(out_ovf), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 64'(in_ready), 64'd0);

        for (int v = 0; v < 6; v++) begin
            open_frame(vecs[v].base);
            for (int k = 0; k < vecs[v].n; k++)
                send_beat(vecs[v].codes[k], (k == vecs[v].n - 1));
            close_frame($sformatf("v%0d", v), vecs[v].exp_sum, vecs[v].exp_cnt, vecs[v].exp_ovf);
        end

        // Result held under backpressure; start ignored in DONE and in the handshake cycle
        open_frame(32'd500);
        send_beat(14'd1, 1'b0);
        send_beat(14'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            chk($sformatf("hold%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("hold%0d_sum", i), 64'(out_sum), 64'd508);
            chk($sformatf("hold%0d_cnt", i), 64'(out_count), 64'd2);
        end
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        chk("hold_vld0", 64'(out_valid), 64'd0);
        chk("hold_idle_rdy", 64'(in_ready), 64'd0);
        tick();
        chk("hold_start_ign", 64'(in_ready), 64'd0);
        $display("frame hold: sum=0x%08h count=%0d", out_sum, out_count);

        // Reset mid-frame discards the frame
        open_frame(32'd50);
        send_beat(14'd5, 1'b0);
        send_beat(14'd6, 1'b0);
        in_valid = 1'b1;
        in_code = 14'd7;
        rst = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(out_sum), 64'd0);
        chk("mid_rst_cnt", 64'(out_count), 64'd0);
        chk("mid_rst_ovf", 64'(out_ovf), 64'd0);
        open_frame(32'd7);
        send_beat(14'd5, 1'b1);
        close_frame("after_rst", 32'd27, 9'd1, 1'b0);

        // Gaps in in_valid leave the frame untouched
        open_frame(32'd1000);
        send_beat(14'd10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gap_ready", 64'(in_ready), 64'd1);
            chk("gap_valid", 64'(out_valid), 64'd0);
        end
        send_beat(14'd20, 1'b1);
        close_frame("gaps", 32'd1120, 9'd2, 1'b0);

        // Beat counter wraps past 511
        open_frame(32'd0);
        for (int k = 0; k < 513; k++)
            send_beat(14'd1, (k == 512));
        close_frame("wrap", 32'd2052, 9'd1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
